// File: rtl/rr_fifo_arbiter_param_pkg.sv
// Shared defaults and sizing helpers for the parametrised round-robin FIFO arbiter.
package rr_fifo_arbiter_param_pkg;

    localparam int DEF_NUM_CH = 4;
    localparam int DEF_DATA_W = 8;
    localparam int DEF_DEPTH  = 8;

    // A count must reach DEPTH itself, so it needs one bit more than a pointer.
    function automatic int cnt_w(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/rr_fifo_arbiter_param_fifo.sv
// Per-channel FIFO: registered pointers/count, combinational head, and drop detection.
module rr_channel_fifo
    import rr_fifo_arbiter_param_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int DEPTH  = DEF_DEPTH,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = cnt_w(DEPTH)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              push,
    input  logic              pop,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata,
    output logic [CNT_W-1:0]  count,
    output logic              full,
    output logic              empty,
    output logic              drop
);

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0]  r_wr_ptr;
    logic [PTR_W-1:0]  r_rd_ptr;
    logic [CNT_W-1:0]  r_count;
    logic              w_pop;
    logic              w_push_ok;

    assign full      = (r_count == CNT_W'(DEPTH));
    assign empty     = (r_count == '0);
    assign w_pop     = pop && !empty;
    // A full FIFO still accepts a write when its head leaves in the same cycle.
    assign w_push_ok = push && (!full || w_pop);
    assign drop      = push && full && !w_pop;
    assign rdata     = r_mem[r_rd_ptr];
    assign count     = r_count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push_ok) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            if (w_pop)     r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            case ({w_push_ok, w_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // NOTE: storage has no reset; the count decides what is valid, so stale words never escape.
    always_ff @(posedge clk) begin
        if (w_push_ok) r_mem[r_wr_ptr] <= wdata;
    end

endmodule

// File: rtl/rr_fifo_arbiter_param.sv
// NUM_CH private FIFOs drained by a work-conserving round-robin arbiter into one registered stream.
module rr_fifo_arbiter_param
    import rr_fifo_arbiter_param_pkg::*;
#(
    parameter int NUM_CH = DEF_NUM_CH,
    parameter int DATA_W = DEF_DATA_W,
    parameter int DEPTH  = DEF_DEPTH,
    localparam int GNT_W = $clog2(NUM_CH),
    localparam int CNT_W = cnt_w(DEPTH)
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [NUM_CH-1:0]        wen,
    input  logic [NUM_CH*DATA_W-1:0] din,
    output logic [NUM_CH-1:0]        full,
    output logic [NUM_CH-1:0]        overflow,
    input  logic                     ovf_clr,
    input  logic                     ready,
    output logic                     valid,
    output logic [DATA_W-1:0]        dout,
    output logic [GNT_W-1:0]         grant_id
);

    logic [DATA_W-1:0] w_rdata [NUM_CH];
    logic [CNT_W-1:0]  w_count [NUM_CH];
    logic [NUM_CH-1:0] w_empty;
    logic [NUM_CH-1:0] w_nonempty;
    logic [NUM_CH-1:0] w_drop;
    logic [NUM_CH-1:0] w_pop;
    logic [GNT_W-1:0]  w_gnt;
    logic              w_load;

    logic              r_valid;
    logic [DATA_W-1:0] r_dout;
    logic [GNT_W-1:0]  r_grant_id;
    logic [GNT_W-1:0]  r_last_grant;
    logic [NUM_CH-1:0] r_overflow;

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        rr_channel_fifo #(.DATA_W(DATA_W), .DEPTH(DEPTH)) u_fifo (
            .clk   (clk),
            .rst_n (rst_n),
            .push  (wen[i]),
            .pop   (w_pop[i]),
            .wdata (din[i*DATA_W +: DATA_W]),
            .rdata (w_rdata[i]),
            .count (w_count[i]),
            .full  (full[i]),
            .empty (w_empty[i]),
            .drop  (w_drop[i])
        );
        assign w_nonempty[i] = (w_count[i] != '0);
    end

    // Search starts just after the previous winner, so every busy channel is served within NUM_CH loads.
    // NOTE: every output of this block gets a default first, so no latch is inferred.
    always_comb begin
        logic found;
        found = 1'b0;
        w_gnt = '0;
        for (int off = 1; off <= NUM_CH; off++) begin
            if (!found && !w_empty[(int'(r_last_grant) + off) % NUM_CH]) begin
                found = 1'b1;
                w_gnt = GNT_W'((int'(r_last_grant) + off) % NUM_CH);
            end
        end
    end

    assign w_load = (!r_valid || ready) && (|w_nonempty);
    assign w_pop  = w_load ? (NUM_CH'(1) << w_gnt) : '0;

    // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid      <= 1'b0;
            r_dout       <= '0;
            r_grant_id   <= '0;
            r_last_grant <= GNT_W'(NUM_CH - 1);
            r_overflow   <= '0;
        end else begin
            if (w_load) begin
                r_valid      <= 1'b1;
                r_dout       <= w_rdata[w_gnt];
                r_grant_id   <= w_gnt;
                r_last_grant <= w_gnt;
            end else if (r_valid && ready) begin
                r_valid <= 1'b0;
            end
            // A drop in the clearing cycle survives the clear.
            r_overflow <= (ovf_clr ? '0 : r_overflow) | w_drop;
        end
    end

    assign valid    = r_valid;
    assign dout     = r_dout;
    assign grant_id = r_grant_id;
    assign overflow = r_overflow;

endmodule
